// File: rtl/imem_loader.sv
// Streaming instruction-memory loader: length header plus little-endian words written to consecutive addresses.
// Optional trailing modulo-256 checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_written
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int MAX_WORDS = (2 ** ADDR_WIDTH) / BYTES;
  localparam int IDX_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [16:0]      MAX_N    = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_END = S_CHECK;
`else
  localparam state_e S_END = S_DONE;
`endif

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [15:0]           words_q, words_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cpu_rst_n_q, busy_q, done_q, error_q;
  logic                  accept;
  logic [15:0]           n_hdr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                    (state_q == S_CHECK) ||
`endif
                    (state_q == S_DATA);
  assign accept   = in_valid && in_ready;
  assign n_hdr    = {in_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    idx_d   = idx_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_LO;
          words_d = '0;
          idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = n_hdr;
          // The size check here is what keeps every write address in range.
          if (n_hdr == 16'd0)             state_d = S_END;
          else if ({1'b0, n_hdr} > MAX_N) state_d = S_ERROR;
          else                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d[idx_q*8 +: 8] = in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + in_data;
`endif
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            we_d    = 1'b1;
            addr_d  = ADDR_WIDTH'(words_q * 16'(BYTES));
            wdata_d = word_d;
            words_d = words_q + 16'd1;
            if (words_d == len_q) state_d = S_END;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      words_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      words_q     <= words_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      // Status flags follow the next state so they settle on the same edge as the transition.
      cpu_rst_n_q <= (state_d == S_IDLE) || (state_d == S_DONE);
      busy_q      <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                     (state_d == S_CHECK) ||
`endif
                     (state_d == S_DATA);
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERROR);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign cpu_rst_n     = cpu_rst_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: basic, empty, full-depth, oversize, gapped and mid-word reset loads.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, cpu_rst_n, busy, done, error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] words_written;

  int          vectors = 0;
  int          miscompares = 0;
  int          wr_cnt = 0;
  logic [7:0]  wr_addr [0:127];
  logic [31:0] wr_data [0:127];
  logic        gaps = 1'b0;
  logic [7:0]  csum = 8'h00;

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we && wr_cnt < 128) begin
      wr_addr[wr_cnt] = mem_addr;
      wr_data[wr_cnt] = mem_wdata;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $error("FAIL in_ready_timeout: observed=0 expected=1");
    end
    @(negedge clk);
    if (gaps) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      csum = csum + w[i*8 +: 8];
      send(w[i*8 +: 8]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_cnt = 0;
    csum = 8'h00;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send(n[7:0]);
    send(n[15:8]);
  endtask

  task automatic finish_stream();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic basic_load(input logic mid_start);
    pulse_start();
    chk("load_busy", {31'd0, busy}, 32'd1);
    chk("load_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
    chk("load_in_ready", {31'd0, in_ready}, 32'd1);
    send_hdr(16'd2);
    send_word(32'h0000_0513);
    if (mid_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    send_word(32'h0010_0593);
  endtask

  task automatic check_basic_writes(input string tag);
    chk({tag, "_wr_cnt"}, wr_cnt, 32'd2);
    chk({tag, "_addr0"}, {24'd0, wr_addr[0]}, 32'h00);
    chk({tag, "_data0"}, wr_data[0], 32'h0000_0513);
    chk({tag, "_addr1"}, {24'd0, wr_addr[1]}, 32'h04);
    chk({tag, "_data1"}, wr_data[1], 32'h0010_0593);
    chk({tag, "_words"}, {16'd0, words_written}, 32'd2);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("rst_flags", {28'd0, busy, done, error, in_ready}, 32'd0);
    chk("rst_words", {16'd0, words_written}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

    // Basic two-word load
    basic_load(1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("basic_cpu_held_for_sum", {31'd0, cpu_rst_n}, 32'd0);
    send(csum);
`endif
    chk("basic_done_first_cycle", {31'd0, done}, 32'd1);
    chk("basic_last_we", {31'd0, mem_we}, 32'd1);
    finish_stream();
    check_basic_writes("basic");
    chk("basic_status", {28'd0, busy, done, error, cpu_rst_n}, 32'b0101);

    // Empty load
    pulse_start();
    send_hdr(16'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    finish_stream();
    chk("empty_wr_cnt", wr_cnt, 32'd0);
    chk("empty_status", {28'd0, busy, done, error, cpu_rst_n}, 32'b0101);

    // Full depth: 64 words, word i = i
    pulse_start();
    send_hdr(16'd64);
    for (int i = 0; i < 64; i++) send_word(32'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(csum);
`endif
    finish_stream();
    chk("full_wr_cnt", wr_cnt, 32'd64);
    chk("full_addr_mid", {24'd0, wr_addr[17]}, 32'h44);
    chk("full_data_mid", wr_data[17], 32'h11);
    chk("full_addr_last", {24'd0, wr_addr[63]}, 32'hFC);
    chk("full_data_last", wr_data[63], 32'h3F);
    chk("full_words", {16'd0, words_written}, 32'd64);
    chk("full_done", {31'd0, done}, 32'd1);

    // Oversize header is rejected, then a valid load recovers
    pulse_start();
    send_hdr(16'd65);
    finish_stream();
    chk("over_wr_cnt", wr_cnt, 32'd0);
    chk("over_status", {28'd0, busy, done, error, cpu_rst_n}, 32'b0010);
    chk("over_in_ready", {31'd0, in_ready}, 32'd0);
    chk("over_words", {16'd0, words_written}, 32'd0);
    pulse_start();
    send_hdr(16'd1);
    send_word(32'hDEAD_BEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(csum);
`endif
    finish_stream();
    chk("recover_wr_cnt", wr_cnt, 32'd1);
    chk("recover_data", wr_data[0], 32'hDEAD_BEEF);
    chk("recover_status", {28'd0, busy, done, error, cpu_rst_n}, 32'b0101);

    // Gapped stream with a start pulse mid-load
    gaps = 1'b1;
    basic_load(1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(csum);
`endif
    gaps = 1'b0;
    finish_stream();
    check_basic_writes("gaps");
    chk("gaps_status", {28'd0, busy, done, error, cpu_rst_n}, 32'b0101);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: words stay written, load fails
    basic_load(1'b0);
    send(8'h00);
    finish_stream();
    check_basic_writes("badsum");
    chk("badsum_status", {28'd0, busy, done, error, cpu_rst_n}, 32'b0010);
`endif

    // Reset after 2 of 4 bytes of the second word
    pulse_start();
    send_hdr(16'd2);
    send_word(32'h0000_0513);
    send(8'h93);
    send(8'h05);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_status", {27'd0, busy, done, error, cpu_rst_n, in_ready}, 32'd0);
    chk("midrst_words", {16'd0, words_written}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_wr_cnt", wr_cnt, 32'd1);
    chk("midrst_idle_cpu", {31'd0, cpu_rst_n}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
